// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Synchronizes, debounces and edge-detects the board push-buttons
//            and switches, with optional per-input auto-repeat on press.
//            Single clock domain (pixel clock).
// Ports    : clk      - pixel clock, the only clock
//            rst      - asynchronous active-high reset
//            btn_raw  - raw asynchronous pin levels, 1 = pressed
//            level    - debounced level
//            press    - 1-cycle pulse per accepted press and per repeat
//            rel      - 1-cycle pulse per accepted release ("release" is a
//                       reserved word, hence the short name)
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
  parameter int               N_BTN            = 9,
  parameter int               TICK_DIV         = 25000,
  parameter int               DEBOUNCE_MS      = 10,
  parameter int               REPEAT_DELAY_MS  = 400,
  parameter int               REPEAT_PERIOD_MS = 100,
  parameter logic [N_BTN-1:0] REPEAT_MASK      = N_BTN'(9'b0_0000_1111)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] rel
);

  localparam int TC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DC_W   = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int RC_MAX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS
                                                               : REPEAT_PERIOD_MS;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [TC_W-1:0] TC_LAST         = TC_W'(TICK_DIV - 1);
  localparam logic [DC_W-1:0] DC_LAST         = DC_W'(DEBOUNCE_MS - 1);
  localparam logic [RC_W-1:0] RC_DELAY_LAST   = RC_W'(REPEAT_DELAY_MS - 1);
  localparam logic [RC_W-1:0] RC_PERIOD_LAST  = RC_W'(REPEAT_PERIOD_MS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

  // --------------------------------------------------------------------------
  // Shared prescaler and two-flop synchronizer
  // --------------------------------------------------------------------------
  logic [TC_W-1:0]  tc_q, tc_d;
  logic             tick;
  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;

  always_comb begin
    tick    = (tc_q == TC_LAST);
    tc_d    = tick ? '0 : tc_q + TC_W'(1);
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_q    <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      tc_q    <= tc_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-input debounce, edge pulses and repeat FSM
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q,   rel_d;
    logic            accept;
    logic            rep_fire;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [RC_W-1:0] rc_q, rc_d;
    rep_state_t      state_q, state_d;

    // Any cycle of agreement restarts the count, so only an unbroken run of
    // DEBOUNCE_MS disagreeing ticks can flip the level.
    always_comb begin : debounce
      level_d = level_q;
      dc_d    = dc_q;
      accept  = 1'b0;
      if (sync2_q[i] == level_q) begin
        dc_d = '0;
      end else if (tick) begin
        if (dc_q == DC_LAST) begin
          level_d = sync2_q[i];
          dc_d    = '0;
          accept  = 1'b1;
        end else begin
          dc_d = dc_q + DC_W'(1);
        end
      end
    end

    // An accepted change while active can only be a release; checking it
    // before the tick is what lets the release suppress a due repeat.
    always_comb begin : repeat_fsm
      state_d  = state_q;
      rc_d     = rc_q;
      rep_fire = 1'b0;
      if (REPEAT_MASK[i]) begin
        case (state_q)
          ST_IDLE: begin
            if (accept && level_d) begin
              state_d = ST_DELAY;
              rc_d    = '0;
            end
          end
          ST_DELAY: begin
            if (accept) begin
              state_d = ST_IDLE;
              rc_d    = '0;
            end else if (tick) begin
              if (rc_q == RC_DELAY_LAST) begin
                rep_fire = 1'b1;
                state_d  = ST_REPEAT;
                rc_d     = '0;
              end else begin
                rc_d = rc_q + RC_W'(1);
              end
            end
          end
          ST_REPEAT: begin
            if (accept) begin
              state_d = ST_IDLE;
              rc_d    = '0;
            end else if (tick) begin
              if (rc_q == RC_PERIOD_LAST) begin
                rep_fire = 1'b1;
                rc_d     = '0;
              end else begin
                rc_d = rc_q + RC_W'(1);
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            rc_d    = '0;
          end
        endcase
      end
    end

    always_comb begin : edges
      press_d = (accept & level_d) | rep_fire;
      rel_d   = accept & ~level_d;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        dc_q    <= '0;
        rc_q    <= '0;
        state_q <= ST_IDLE;
      end else begin
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        dc_q    <= dc_d;
        rc_q    <= rc_d;
        state_q <= state_d;
      end
    end

    assign level[i] = level_q;
    assign press[i] = press_q;
    assign rel[i]   = rel_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Self-checking bench for btn_conditioner. Every cycle is compared
//            against a timing model expressed in absolute cycle arithmetic,
//            plus directed pulse-count records and multi-cycle corner cases.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

  localparam int         NB   = 9;
  localparam int         TD   = 4;
  localparam int         DB   = 3;
  localparam int         RD   = 5;
  localparam int         RP   = 2;
  localparam logic [8:0] MASK = 9'h00F;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] btn_raw;
  logic [8:0] level, press, rel;

  btn_conditioner #(
    .N_BTN(NB), .TICK_DIV(TD), .DEBOUNCE_MS(DB),
    .REPEAT_DELAY_MS(RD), .REPEAT_PERIOD_MS(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .level(level), .press(press), .rel(rel)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: k counts clock edges since reset release. Ticks land on edges
  // where k is a multiple of TD. The pins reach the debouncer two edges late.
  int         k;
  logic [8:0] hist[$];
  int         dis_start[NB];
  int         acc_t[NB];
  bit         held[NB];
  logic [8:0] m_level, m_press, m_rel;

  function automatic void model_reset();
    k = 0;
    hist.delete();
    m_level = '0; m_press = '0; m_rel = '0;
    for (int i = 0; i < NB; i++) begin
      dis_start[i] = -1; acc_t[i] = 0; held[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input logic [8:0] r);
    logic [8:0] s;
    bit         acc;
    int         d;
    k++;
    hist.push_back(r);
    if (hist.size() > 3) void'(hist.pop_front());
    s = (hist.size() == 3) ? hist[0] : 9'h000;
    m_press = '0;
    m_rel   = '0;
    for (int i = 0; i < NB; i++) begin
      acc = 1'b0;
      if (s[i] != m_level[i]) begin
        if (dis_start[i] < 0) dis_start[i] = k;
        // accept on the DB-th tick inside the unbroken disagreement run
        if ((k % TD == 0) && ((k / TD) - ((dis_start[i] - 1) / TD) == DB)) begin
          acc = 1'b1;
          m_level[i] = s[i];
          dis_start[i] = -1;
          if (s[i]) begin
            m_press[i] = 1'b1;
            if (MASK[i]) begin held[i] = 1'b1; acc_t[i] = k; end
          end else begin
            m_rel[i] = 1'b1;
            held[i]  = 1'b0;
          end
        end
      end else begin
        dis_start[i] = -1;
      end
      if (!acc && held[i]) begin
        d = k - acc_t[i];
        if (d >= RD * TD && (d - RD * TD) % (RP * TD) == 0) m_press[i] = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs();
    vectors++;
    if (level !== m_level || press !== m_press || rel !== m_rel) begin
      miscompares++;
      $display("FAIL cycle k=%0d level=%h exp %h press=%h exp %h rel=%h exp %h",
               k, level, m_level, press, m_press, rel, m_rel);
    end
    vectors++;
    if ((press & rel) !== 9'h000) begin
      miscompares++;
      $display("FAIL press_and_rel k=%0d press=%h rel=%h exp no overlap", k, press, rel);
    end
  endtask

  task automatic check_zero(input string tag);
    vectors++;
    if ({level, press, rel} !== 27'h0) begin
      miscompares++;
      $display("FAIL %s level=%h press=%h rel=%h exp all 0", tag, level, press, rel);
    end
  endtask

  // Called just after an edge (or at a negedge right after reset release).
  task automatic step(input logic [8:0] r);
    btn_raw = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_outputs();
  endtask

  task automatic reset_assert();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("rst_async");
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    check_zero("rst_hold");
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [8:0] raw;
    int         hold;
    int         bitn;
    int         exp_press;
    int         exp_rel;
  } rec_t;

  localparam int NREC = 6;
  rec_t       tbl[NREC];
  int         first_p[NB];
  int         cnt_p[NB];
  int         pc, rc, t1, gap, nseg;
  logic [8:0] r;

  initial begin
    // raw, hold cycles, observed bit, presses, releases (30 idle cycles follow)
    tbl[0] = '{9'h010,  7, 4, 0, 0};   // glitch on C
    tbl[1] = '{9'h004, 72, 2, 8, 1};   // L: edge + 7 repeats
    tbl[2] = '{9'h020, 60, 5, 1, 1};   // btn1 masked off
    tbl[3] = '{9'h002, 36, 1, 3, 1};   // D: release lands on a due repeat
    tbl[4] = '{9'h100, 16, 8, 1, 1};   // btn4 short hold
    tbl[5] = '{9'h008, 24, 3, 2, 1};   // R: exactly one repeat

    // Reset with every input held
    rst = 1'b1;
    btn_raw = 9'h1FF;
    model_reset();
    #1;
    check_zero("rst_initial");
    repeat (3) reset_cycle();
    reset_release();
    for (int i = 0; i < NB; i++) begin first_p[i] = -1; cnt_p[i] = 0; end
    for (int n = 1; n <= 14; n++) begin
      step(9'h1FF);
      for (int i = 0; i < NB; i++) if (press[i]) begin
        cnt_p[i]++;
        if (first_p[i] < 0) first_p[i] = n;
      end
    end
    for (int i = 0; i < NB; i++) begin
      vectors++;
      if (cnt_p[i] != 1 || first_p[i] < 11 || first_p[i] > 15) begin
        miscompares++;
        $display("FAIL reset_press bit=%0d count=%0d at=%0d exp 1 pulse in 11..15",
                 i, cnt_p[i], first_p[i]);
      end
    end
    repeat (30) step(9'h000);

    // Directed records
    for (int t = 0; t < NREC; t++) begin
      pc = 0; rc = 0;
      for (int n = 0; n < tbl[t].hold + 30; n++) begin
        step((n < tbl[t].hold) ? tbl[t].raw : 9'h000);
        pc += int'(press[tbl[t].bitn]);
        rc += int'(rel[tbl[t].bitn]);
      end
      vectors++;
      if (pc != tbl[t].exp_press || rc != tbl[t].exp_rel) begin
        miscompares++;
        $display("FAIL record%0d bit=%0d press=%0d rel=%0d exp press=%0d rel=%0d",
                 t, tbl[t].bitn, pc, rc, tbl[t].exp_press, tbl[t].exp_rel);
      end
      vectors++;
      if (level !== 9'h000) begin
        miscompares++;
        $display("FAIL record%0d_idle level=%h exp 000", t, level);
      end
    end

    // Reset while bit 0 is repeating, button kept held
    pc = 0;
    for (int n = 0; n < 60 && pc < 2; n++) begin
      step(9'h001);
      pc += int'(press[0]);
    end
    vectors++;
    if (pc < 2) begin
      miscompares++;
      $display("FAIL reach_repeat presses=%0d exp 2 within 60 cycles", pc);
    end
    repeat (3) step(9'h001);
    reset_assert();
    reset_cycle();
    reset_release();
    t1 = -1;
    for (int n = 1; n <= 30 && t1 < 0; n++) begin
      step(9'h001);
      if (press[0]) t1 = n;
    end
    vectors++;
    if (t1 < 11 || t1 > 15) begin
      miscompares++;
      $display("FAIL rerst_press at=%0d exp 11..15", t1);
    end
    gap = -1;
    for (int n = 1; n <= 40 && gap < 0; n++) begin
      step(9'h001);
      if (press[0]) gap = n;
    end
    vectors++;
    if (gap != RD * TD) begin
      miscompares++;
      $display("FAIL rerst_first_repeat gap=%0d exp %0d", gap, RD * TD);
    end
    repeat (30) step(9'h000);

    // Random segments against the model
    nseg = 0;
    while (nseg < 60) begin
      r = 9'($urandom);
      repeat ($urandom_range(1, 40)) step(r);
      nseg++;
    end
    repeat (30) step(9'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
# btn_conditioner

Conditions the raw push-button and switch inputs before they reach the scene logic. Each of the nine board inputs is passed through a two-flop synchronizer, debounced against a shared millisecond tick, and converted into a clean level, a one-cycle press pulse with optional auto-repeat, and a one-cycle release pulse. The block sits between the board pins and the scene module, in the 25 MHz pixel-clock domain.

## Interface

Parameters:
- `N_BTN`, default 9: number of inputs. Bit order is 0=U, 1=D, 2=L, 3=R, 4=C, 5..8=btn1..btn4.
- `TICK_DIV`, default 25000: clk cycles per tick (1 ms at 25 MHz).
- `DEBOUNCE_MS`, default 10: consecutive disagreeing ticks needed to accept a new level. Must be ≥1.
- `REPEAT_DELAY_MS`, default 400: ticks from accepted press to the first repeat pulse. Must be ≥1.
- `REPEAT_PERIOD_MS`, default 100: ticks between subsequent repeat pulses. Must be ≥1.
- `REPEAT_MASK`, default 9'b0_0000_1111: per-input auto-repeat enable (directions only).

Ports:
- `clk`, input, 1: pixel clock; the only clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `btn_raw`, input, N_BTN: raw, asynchronous pin levels (1 = pressed).
- `level`, output, N_BTN: debounced level.
- `press`, output, N_BTN: one-cycle pulse on each accepted press and on each repeat.
- `release`, output, N_BTN: one-cycle pulse on each accepted release.

## Operation

- **Synchronizer:** two flops per bit, reset to 0. The synchronized bit is `s[i]`.
- **Prescaler:** counter `0..TICK_DIV-1`, wraps to 0. `tick` is asserted for the one cycle in which the counter equals `TICK_DIV-1`. The tick is shared by all inputs.
- **Debounce, per bit, count `dc`:**
  - If `s[i]==level[i]`, clear `dc` to 0 on every cycle.
  - Otherwise, on `tick`: if `dc==DEBOUNCE_MS-1`, then `level[i]<=s[i]` and `dc<=0`; else `dc<=dc+1`.
  - A glitch shorter than DEBOUNCE_MS ticks never changes `level`.
- **Edge pulses:** registered together with `level`.
  - `press[i]`=1 in the first cycle `level[i]` reads 1.
  - `release[i]`=1 in the first cycle `level[i]` reads 0.
- **Repeat FSM, per bit, counter `rc`:** only for bits with `REPEAT_MASK[i]`=1. Masked-off bits stay in IDLE and produce edge pulses only.
  - IDLE: on accepted press, go to DELAY with `rc=0`.
  - DELAY: on `tick`, if `rc==REPEAT_DELAY_MS-1`, then `press[i]` pulses, state goes to REPEAT and `rc=0`; else `rc+1`.
  - REPEAT: on `tick`, if `rc==REPEAT_PERIOD_MS-1`, then `press[i]` pulses and `rc=0`; else `rc+1`.
  - Accepted release in DELAY or REPEAT: go to IDLE, `rc=0`.
- **Simultaneous events:** an accepted release in the same cycle as a due repeat suppresses that repeat pulse; only `release` fires. `press` and `release` are never high together for one bit.
- **Counter widths:** `$clog2` of the relevant maximum, no overflow. Comparisons are equality only.

## Timing

- **Reset:** `level`, `press`, `release`, sync flops, prescaler, `dc`, `rc` all 0; every FSM in IDLE. Reset takes effect immediately and asynchronously, including mid-debounce or mid-repeat.
- **Input held through reset release:** the input is treated as a new press and is accepted after normal debounce.
- **Latency:** from a clean raw edge (held stable) to `level`/`press` change, between `2+(DEBOUNCE_MS-1)*TICK_DIV+1` and `2+DEBOUNCE_MS*TICK_DIV+1` clk cycles, depending on tick phase.
- **First repeat:** exactly `REPEAT_DELAY_MS*TICK_DIV` cycles after the edge `press`, ±`TICK_DIV` depending on tick phase at entry.
- **Later repeats:** every `REPEAT_PERIOD_MS*TICK_DIV` cycles, exactly.
- **Pulse width:** every pulse is exactly 1 clk wide.
- **Independence:** all inputs are independent; any number may pulse in the same cycle.

## Test plan

Sim parameters: `TICK_DIV`=4, `DEBOUNCE_MS`=3, `REPEAT_DELAY_MS`=5, `REPEAT_PERIOD_MS`=2.

- **Reset:** assert `rst` with `btn_raw`=9'h1FF. Required: all outputs 0 during reset. After release, all nine `press` bits pulse once, within 2+8+1..2+12+1 cycles.
- **Glitch rejection:** btnC high for 7 cycles, then low. Required: `level[4]`, `press[4]`, `release[4]` stay 0 throughout.
- **Auto-repeat:** hold btnL (bit 2) for 60 cycles after its edge press. Required: first repeat 20±4 cycles after the edge pulse, then pulses exactly every 8 cycles; release gives one `release[2]` pulse and no further `press`.
- **Masked-off input:** hold btn1 (bit 5) for 60 cycles. Required: exactly one `press[5]` and no repeats.
- **Release wins over a due repeat:** time the release so that the accepted release lands on a repeat tick. Required: `release`=1 and `press`=0 in that cycle.
- **Reset mid-repeat:** assert `rst` while bit 0 is in REPEAT, for 1 cycle, with the button still held. Required: outputs clear at once; a fresh edge `press[0]` follows after debounce, and the first repeat comes only after a full `REPEAT_DELAY_MS`.
